// File: rtl/alu_ctrl_md_seq_if.sv
// Decode/sequencer bus between the main control unit and the ALU control unit.
// The master drives the instruction fields; the slave returns the control outputs.
interface alu_ctrl_md_seq_if #(
  parameter int CTRL_W = 4
);
  logic              valid_in;
  logic [1:0]        alu_op;
  logic [5:0]        func;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              illegal;
  logic              md_start;
  logic [1:0]        md_op;
  logic              md_busy;
  logic              hilo_we;
  logic              stall;

  modport master (
    output valid_in, alu_op, func,
    input  alu_ctrl, illegal, md_start, md_op, md_busy, hilo_we, stall
  );

  modport slave (
    input  valid_in, alu_op, func,
    output alu_ctrl, illegal, md_start, md_op, md_busy, hilo_we, stall
  );
endinterface

// File: rtl/alu_ctrl_md_seq.sv
// ALU control decode plus a multi-cycle MULT/DIV sequencer (start, busy count,
// HI/LO write, dependent-instruction stall).
module alu_ctrl_md_seq #(
  parameter int CTRL_W  = 4,
  parameter int MD_EN   = 1,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input logic              clk,
  input logic              rst_n,
  alu_ctrl_md_seq_if.slave bus
);
  localparam bit MD     = (MD_EN != 0);
  localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW     = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;
  localparam logic [CW-1:0] MUL_LD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_LAT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [1:0]        md_op_q;
  logic [3:0]        code;
  logic              legal, is_md, is_hl;
  logic              start, done;
  logic [CTRL_W-1:0] ctrl_ext;

  always_comb begin
    code  = 4'h0;
    legal = 1'b1;
    is_md = 1'b0;
    is_hl = 1'b0;
    case (bus.alu_op)
      2'b00: code = 4'h0;
      2'b01: code = 4'h1;
      2'b11: code = 4'h3;
      default: begin
        case (bus.func)
          6'b100000, 6'b100001: code = 4'h0;
          6'b100010, 6'b100011: code = 4'h1;
          6'b100100: code = 4'h2;
          6'b100101: code = 4'h3;
          6'b100110: code = 4'h4;
          6'b100111: code = 4'h5;
          6'b101010: code = 4'h6;
          6'b101011: code = 4'h7;
          6'b000000: code = 4'h8;
          6'b000010: code = 4'h9;
          6'b000011: code = 4'hA;
          6'b010000: begin
            code  = MD ? 4'hB : 4'h0;
            legal = MD;
            is_hl = MD;
          end
          6'b010010: begin
            code  = MD ? 4'hC : 4'h0;
            legal = MD;
            is_hl = MD;
          end
          6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
            legal = MD;
            is_md = MD;
          end
          default: legal = 1'b0;
        endcase
      end
    endcase
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (bus.valid_in && is_md) begin
        start    = 1'b1;
        state_nx = BUSY;
      end
      BUSY: if (cnt == '0) state_nx = DONE;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Every observable output except md_op is held low while reset is asserted.
    start = start && rst_n;
    done  = done && rst_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      md_op_q <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        md_op_q <= bus.func[1:0];
        cnt     <= bus.func[1] ? DIV_LD : MUL_LD;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  always_comb begin
    ctrl_ext      = '0;
    ctrl_ext[3:0] = code;
    if (!rst_n) ctrl_ext = '0;
  end

  assign bus.alu_ctrl = ctrl_ext;
  assign bus.illegal  = rst_n && bus.valid_in && !legal;
  assign bus.md_start = start;
  assign bus.md_op    = md_op_q;
  assign bus.md_busy  = rst_n && (state != IDLE);
  assign bus.hilo_we  = done;
  assign bus.stall    = rst_n && bus.valid_in && (state != IDLE) && (is_md || is_hl);
endmodule
